// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches from ALU flags, trains a
// PC-indexed table of 2-bit saturating counters and serves predictions to fetch.
// A misprediction is reported one cycle after resolution, with a registered redirect PC.
// Optional build macro BRANCH_STATS_EN adds saturating branch/mispredict counters.

// One predictor entry: 2-bit saturating counter, reset to weakly not-taken.
module bru_bht_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] ctr
);
  // Count toward the observed outcome and hold at either end of the range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ctr <= 2'b01;
    else if (upd) begin
      if (taken && ctr != 2'b11)
        ctr <= ctr + 2'd1;
      else if (!taken && ctr != 2'b00)
        ctr <= ctr - 2'd1;
    end
  end
endmodule

module branch_resolve_unit #(
  parameter int              PC_W      = 16,
  parameter int              OPC_W     = 5,
  parameter int              BHT_DEPTH = 16,
  parameter logic [OPC_W-1:0] BEQ_OP   = 5'b10011,
  parameter logic [OPC_W-1:0] BLT_OP   = 5'b10100,
  parameter logic [OPC_W-1:0] BGT_OP   = 5'b10101,
  parameter logic [OPC_W-1:0] BNE_OP   = 5'b10110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [OPC_W-1:0] res_opcode,
  input  logic [1:0]      res_flags,
  input  logic [PC_W-1:0] res_pc,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_pred_taken,
  output logic            branch_taken,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     br_count,
  output logic [15:0]     mispred_count
`endif
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [BHT_DEPTH-1:0][1:0] bht;
  logic [IDX_W-1:0]          res_idx, pred_idx;
  logic                      is_beq, is_blt, is_bgt, is_bne, is_br;
  logic                      flag_z, flag_n, taken, miss;

  assign flag_z = res_flags[1];
  assign flag_n = res_flags[0];

  // Decode: exact opcode match so an X/Z opcode never looks like a branch.
  assign is_beq = res_valid && (res_opcode === BEQ_OP);
  assign is_blt = res_valid && (res_opcode === BLT_OP);
  assign is_bgt = res_valid && (res_opcode === BGT_OP);
  assign is_bne = res_valid && (res_opcode === BNE_OP);
  assign is_br  = is_beq | is_blt | is_bgt | is_bne;

  assign taken = (is_beq & flag_z) | (is_bne & ~flag_z) |
                 (is_blt & flag_n) | (is_bgt & ~flag_n);
  assign miss  = is_br && (taken != res_pred_taken);

  // Low PC bits index the table; aliasing between PCs is accepted (no tags).
  assign res_idx  = res_pc[IDX_W-1:0];
  assign pred_idx = pred_pc[IDX_W-1:0];

  // Upper PC bits of the predict side are deliberately not used.
  logic unused_pred_pc_hi;
  assign unused_pred_pc_hi = ^pred_pc[PC_W-1:IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      bru_bht_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .upd   (is_br && (res_idx == IDX_W'(gi))),
        .taken (taken),
        .ctr   (bht[gi])
      );
    end
  endgenerate

  // Prediction reads the current table state; a same-cycle update is not bypassed.
  assign pred_taken = pred_valid & bht[pred_idx][1];

  // Register the outcome; redirect_pc only moves on a resolved branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      branch_taken <= taken;
      mispredict   <= miss;
      if (is_br)
        redirect_pc <= taken ? res_target : res_pc + PC_W'(1);
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating event counters for branches seen and mispredicts flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (is_br && br_count != 16'hFFFF)
        br_count <= br_count + 16'd1;
      if (miss && mispred_count != 16'hFFFF)
        mispred_count <= mispred_count + 16'd1;
    end
  end
`endif

endmodule
